// File: rtl/seg7_step_sequencer_if.sv
// Control and display signals between the step sequencer and its environment.
// The 7-segment decoder consumes counter; buttons and rate controls come from the board.
interface seg7_step_sequencer_if;
    logic       ena;
    logic       run_btn;
    logic       step_btn;
    logic       dir;
    logic [1:0] rate_sel;
    logic [3:0] counter;
    logic       step_pulse;
    logic       running;

    modport master (
        output ena, run_btn, step_btn, dir, rate_sel,
        input  counter, step_pulse, running
    );

    modport slave (
        input  ena, run_btn, step_btn, dir, rate_sel,
        output counter, step_pulse, running
    );
endinterface

// File: rtl/seg7_step_sequencer.sv
// Step-index generator for the 7-segment decoder: debounced run/step buttons drive an
// IDLE/RUN/PAUSE machine that advances a wrapping index at a selectable prescaled rate.
module seg7_step_sequencer #(
    parameter int DIV_BASE   = 1000000,
    parameter int PRESC_W    = 24,
    parameter int DEB_CYCLES = 50000,
    parameter int LAST_STEP  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_step_sequencer_if.slave  bus
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               sync1_q, sync2_q;
    logic [1:0]               lvl_q, lvl_d;
    logic [1:0]               press_q, press_d;
    logic [1:0][DEB_W-1:0]    cnt_q, cnt_d;
    logic [PRESC_W-1:0]       presc_q, presc_d;
    logic [PRESC_W-1:0]       period_m1;
    logic [3:0]               counter_q, counter_d;
    logic                     step_pulse_q, running_q, running_d;
    logic                     run_p, step_p, tick, advance;
    logic [1:0]               raw;

    // Bit 0 is the run button, bit 1 the step button throughout the button path.
    assign raw    = {bus.step_btn, bus.run_btn};
    assign run_p  = press_q[0];
    assign step_p = press_q[1];

    // A level change is accepted on the DEB_CYCLES-th consecutive mismatching cycle.
    always_comb begin
        lvl_d   = lvl_q;
        press_d = '0;
        cnt_d   = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != lvl_q[b]) begin
                if (cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    lvl_d[b]   = sync2_q[b];
                    press_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            cnt_q   <= '0;
            press_q <= '0;
        end else if (bus.ena) begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end else begin
            press_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (bus.ena) begin
            state_q <= state_d;
        end
    end

    // Run press takes priority, so a simultaneous step press is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run_p)       state_d = S_RUN;
                else if (step_p) state_d = S_PAUSE;
            end
            S_RUN:   if (run_p) state_d = S_PAUSE;
            S_PAUSE: if (run_p) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    assign period_m1 = (PRESC_W'(DIV_BASE) << bus.rate_sel) - PRESC_W'(1);

    // Prescaler only runs while staying in RUN; any entry/exit restarts it from 0.
    always_comb begin
        tick      = 1'b0;
        presc_d   = '0;
        counter_d = counter_q;
        if (state_q == S_RUN && state_d == S_RUN) begin
            if (presc_q >= period_m1) tick = 1'b1;
            else                      presc_d = presc_q + 1'b1;
        end
        advance = tick | ((state_q != S_RUN) & step_p & ~run_p);
        if (advance) begin
            if (bus.dir)
                counter_d = (counter_q == 4'd0) ? 4'(LAST_STEP) : counter_q - 4'd1;
            else
                counter_d = (counter_q == 4'(LAST_STEP)) ? 4'd0 : counter_q + 4'd1;
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            counter_q    <= '0;
            running_q    <= 1'b0;
            step_pulse_q <= 1'b0;
        end else if (bus.ena) begin
            presc_q      <= presc_d;
            counter_q    <= counter_d;
            running_q    <= running_d;
            step_pulse_q <= advance;
        end else begin
            step_pulse_q <= 1'b0;
        end
    end

    assign bus.counter    = counter_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.running    = running_q;

endmodule

// File: tb/tb_seg7_step_sequencer.sv
// Scoreboard bench for seg7_step_sequencer: a behavioural model predicts the outputs
// after every clock edge; a negedge monitor pops and compares them with the DUT.
module tb_seg7_step_sequencer;

    localparam int DIV_BASE   = 4;
    localparam int PRESC_W    = 8;
    localparam int DEB_CYCLES = 3;
    localparam int LAST_STEP  = 7;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seg7_step_sequencer_if bus ();

    seg7_step_sequencer #(
        .DIV_BASE   (DIV_BASE),
        .PRESC_W    (PRESC_W),
        .DEB_CYCLES (DEB_CYCLES),
        .LAST_STEP  (LAST_STEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int sp;
        int run;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: per-button raw history, accepted level and mismatch run length.
    int m_state = M_IDLE, m_presc = 0, m_cnt = 0, m_sp = 0;
    int m_h1[2], m_h2[2], m_lvl[2], m_run[2], m_press[2];
    int m_raw[2];

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_presc = 0; m_cnt = 0; m_sp = 0;
        for (int b = 0; b < 2; b++) begin
            m_h1[b] = 0; m_h2[b] = 0; m_lvl[b] = 0; m_run[b] = 0; m_press[b] = 0;
        end
    endtask

    initial model_reset();

    always @(posedge clk) begin : model
        int rp, sp, tick, adv, nxt, period;
        exp_t e;
        if (!rst_n) begin
            model_reset();
        end else if (bus.ena) begin
            m_raw[0] = int'(bus.run_btn);
            m_raw[1] = int'(bus.step_btn);
            rp = m_press[0];
            sp = m_press[1];
            period = DIV_BASE << bus.rate_sel;
            nxt = m_state;
            if (rp != 0)                            nxt = (m_state == M_RUN) ? M_PAUSE : M_RUN;
            else if (sp != 0 && m_state == M_IDLE)  nxt = M_PAUSE;
            tick = (m_state == M_RUN && nxt == M_RUN && m_presc >= period - 1) ? 1 : 0;
            adv  = (tick != 0 || (m_state != M_RUN && sp != 0 && rp == 0)) ? 1 : 0;
            if (adv != 0) begin
                if (bus.dir) m_cnt = (m_cnt + LAST_STEP) % (LAST_STEP + 1);
                else         m_cnt = (m_cnt + 1) % (LAST_STEP + 1);
            end
            m_presc = (m_state == M_RUN && nxt == M_RUN && tick == 0) ? m_presc + 1 : 0;
            m_state = nxt;
            m_sp    = adv;
            for (int b = 0; b < 2; b++) begin
                m_press[b] = 0;
                if (m_h2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB_CYCLES) begin
                        m_lvl[b]   = m_h2[b];
                        m_press[b] = m_lvl[b];
                        m_run[b]   = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_h2[b] = m_h1[b];
                m_h1[b] = m_raw[b];
            end
        end else begin
            m_sp = 0;
            m_press[0] = 0;
            m_press[1] = 0;
        end
        e.cnt = m_cnt;
        e.sp  = m_sp;
        e.run = (m_state == M_RUN) ? 1 : 0;
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
        end else begin
            e = exp_q.pop_front();
            if (!rst_n) begin
                e.cnt = 0; e.sp = 0; e.run = 0;
            end
            chk("counter",    int'(bus.counter),    e.cnt);
            chk("step_pulse", int'(bus.step_pulse), e.sp);
            chk("running",    int'(bus.running),    e.run);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input int which, input int hold, input int gap);
        if (which == 0) bus.run_btn = 1'b1; else bus.step_btn = 1'b1;
        cyc(hold);
        if (which == 0) bus.run_btn = 1'b0; else bus.step_btn = 1'b0;
        cyc(gap);
    endtask

    initial begin
        bus.ena = 1'b1; bus.run_btn = 1'b0; bus.step_btn = 1'b0;
        bus.dir = 1'b0; bus.rate_sel = 2'd0;
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(100);

        // Hold run: steps every DIV_BASE clocks and wraps past LAST_STEP.
        bus.run_btn = 1'b1;
        cyc(60);
        bus.dir = 1'b1; bus.rate_sel = 2'd2;
        cyc(70);
        bus.rate_sel = 2'd3;
        cyc(22);
        bus.rate_sel = 2'd0;
        cyc(10);
        bus.run_btn = 1'b0;
        cyc(8);

        // Pause, then single steps upward, then simultaneous run+step.
        press(0, 6, 50);
        bus.dir = 1'b0;
        for (int i = 0; i < 3; i++) press(1, 6, 8);
        bus.run_btn = 1'b1; bus.step_btn = 1'b1;
        cyc(6);
        bus.run_btn = 1'b0; bus.step_btn = 1'b0;
        cyc(30);

        // Glitches shorter than the debounce window, then a real press and bouncy release.
        press(0, 1, 3);
        press(0, 2, 5);
        bus.run_btn = 1'b1;
        cyc(5);
        for (int i = 0; i < 3; i++) begin
            bus.run_btn = 1'b0; cyc(1);
            bus.run_btn = 1'b1; cyc(1);
        end
        bus.run_btn = 1'b0;
        cyc(20);

        // Resume, freeze with ena=0, continue, then async reset mid-run.
        press(0, 6, 8);
        bus.ena = 1'b0;
        cyc(20);
        bus.ena = 1'b1;
        cyc(30);
        rst_n = 1'b0;
        #1;
        chk("rst_counter",    int'(bus.counter),    0);
        chk("rst_running",    int'(bus.running),    0);
        chk("rst_step_pulse", int'(bus.step_pulse), 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(10);

        // Randomised button, direction, rate, enable and occasional reset activity.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            bus.run_btn  = ($urandom_range(0, 3) == 0);
            bus.step_btn = ($urandom_range(0, 2) == 0);
            bus.dir      = $urandom_range(0, 1) != 0;
            if (r < 15) bus.rate_sel = 2'($urandom_range(0, 3));
            bus.ena = (r < 92);
            if (r == 99) rst_n = 1'b0;
            cyc(int'($urandom_range(1, 8)));
            rst_n = 1'b1;
        end
        bus.ena = 1'b1; bus.run_btn = 1'b0; bus.step_btn = 1'b0;
        cyc(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_step_sequencer.md
Name: seg7_step_sequencer

Overview:
- Upstream driver for the 7-segment pattern decoder: generates the 4-bit step index (0..LAST_STEP) that the decoder turns into segment patterns.
- Steps the index at a selectable rate with a run/pause/single-step state machine driven by two debounced push-buttons and a direction input.
- All logic runs on one clock; raw buttons are asynchronous and are synchronised internally.

Parameters:
- DIV_BASE, 1000000, base prescaler period in clocks (rate_sel=0); must be >= 2.
- PRESC_W, 24, prescaler counter width; must hold DIV_BASE*8-1.
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a button level change; must be >= 1.
- LAST_STEP, 7, highest step index produced; range 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; when 0, FSM, prescaler, counter and debouncers hold state
- run_btn  input  1  raw asynchronous run/pause button, active-high
- step_btn  input  1  raw asynchronous single-step button, active-high
- dir  input  1  step direction: 0 = up, 1 = down; sampled on each step
- rate_sel  input  2  step period = DIV_BASE << rate_sel clocks
- counter  output  4  current step index to the decoder
- step_pulse  output  1  one-cycle pulse in the first cycle counter shows a new value
- running  output  1  high while FSM is in RUN

Behaviour:
- Reset (async, rst_n=0): counter=0, step_pulse=0, running=0, FSM=IDLE, prescaler=0, synchronisers and debounced levels=0, debounce counters=0.
- Button path, per button:
  - 2-FF synchroniser.
  - Debounced level flips only after the synchronised level differs from it for DEB_CYCLES consecutive cycles; any mismatch gap clears the count.
  - Press event is a one-cycle pulse on a debounced 0->1 transition. Release generates nothing.
  - A stable raw rise yields its press pulse 2+DEB_CYCLES cycles later.
- FSM states IDLE, RUN, PAUSE; transitions act on press pulses:
  - IDLE: run -> RUN; step -> advance once, go to PAUSE.
  - RUN: run -> PAUSE; step ignored.
  - PAUSE: run -> RUN; step -> advance once, stay in PAUSE.
  - Same-cycle run and step press: run wins, step is dropped.
- Prescaler:
  - Counts only in RUN; cleared to 0 on entering or leaving RUN.
  - Tick when prescaler >= (DIV_BASE << rate_sel) - 1; prescaler then returns to 0.
  - A rate_sel change mid-count takes effect immediately; if the count is already past the new period, tick on the next cycle.
  - First tick after entering RUN occurs a full period later.
- Advance (from a tick or a single step):
  - dir=0: counter+1, with LAST_STEP -> 0.
  - dir=1: counter-1, with 0 -> LAST_STEP.
  - counter updates on the edge after the tick/press cycle; step_pulse is high for exactly that one cycle. Values > LAST_STEP are never produced.
- running is registered and equals (state==RUN).
- ena=0: all state frozen, step_pulse forced 0, press pulses lost. Debouncers resume from held state when ena returns to 1.
- Reset asserted mid-run returns everything to reset values immediately. No step is emitted on reset release.

Test Plan:
- Reset/idle (DIV_BASE=4, DEB_CYCLES=3, rate_sel=0): no buttons for 100 cycles -> counter=0, running=0, step_pulse never high.
- Run up with wrap: press and hold run_btn -> running=1; counter steps every 4 clocks through 1,2,...,7,0,1. Each step has exactly one step_pulse.
- Direction and rate: dir=1, rate_sel=2 while RUN at counter=2 -> counter 1, 0, 7, 6 at 16-clock spacing. A rate_sel change 3->0 with prescaler=20 ticks on the next cycle.
- Pause/step: run press while RUN at counter=5 -> running=0, counter holds 5 for 50 cycles. Three step presses with dir=0 -> 6, 7, 0. A simultaneous run+step press -> RUN resumes with no extra step.
- Debounce: run_btn glitches of 1 and 2 cycles separated by low cycles -> no state change. A 3+-cycle stable high -> exactly one press. Bouncy release -> no event.
- ena/reset: ena=0 for 20 cycles mid-RUN -> counter and prescaler frozen, no step_pulse; resume continues the period. rst_n low mid-RUN at counter=4 -> counter=0, running=0 immediately.
